// File: rtl/wbxbc_pkg.sv
// Shared definitions for the Wishbone target RAM slice: response pipeline
// depth bounds and a helper to validate a requested latency.
package wbxbc_pkg;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 8;

  function automatic bit latency_ok(input int unsigned lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/wb_tgt_ram_if.sv
// Pipelined Wishbone target-side bus bundle; master drives requests,
// slave returns terminations and stall.
interface wb_tgt_ram_if #(
  parameter int unsigned ADR_WIDTH  = 8,
  parameter int unsigned DAT_WIDTH  = 16,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned TGA_WIDTH  = 1,
  parameter int unsigned TGRD_WIDTH = 1
);

  logic                  tgt_cyc_i;
  logic                  tgt_stb_i;
  logic                  tgt_we_i;
  logic [SEL_WIDTH-1:0]  tgt_sel_i;
  logic [ADR_WIDTH-1:0]  tgt_adr_i;
  logic [DAT_WIDTH-1:0]  tgt_dat_i;
  logic [TGA_WIDTH-1:0]  tgt_tga_i;
  logic                  tgt_ack_o;
  logic                  tgt_err_o;
  logic                  tgt_rty_o;
  logic                  tgt_stall_o;
  logic [DAT_WIDTH-1:0]  tgt_dat_o;
  logic [TGRD_WIDTH-1:0] tgt_tgd_o;

  modport master (
    output tgt_cyc_i, tgt_stb_i, tgt_we_i, tgt_sel_i, tgt_adr_i, tgt_dat_i, tgt_tga_i,
    input  tgt_ack_o, tgt_err_o, tgt_rty_o, tgt_stall_o, tgt_dat_o, tgt_tgd_o
  );

  modport slave (
    input  tgt_cyc_i, tgt_stb_i, tgt_we_i, tgt_sel_i, tgt_adr_i, tgt_dat_i, tgt_tga_i,
    output tgt_ack_o, tgt_err_o, tgt_rty_o, tgt_stall_o, tgt_dat_o, tgt_tgd_o
  );

endinterface

// File: rtl/wb_tgt_ram_rsp_pipe.sv
// Fixed-depth response slot shift register; clr empties every slot so
// pending terminations are discarded on reset or bus-cycle abort.
module wb_tgt_ram_rsp_pipe
  import wbxbc_pkg::*;
#(
  parameter int unsigned DAT_WIDTH  = 16,
  parameter int unsigned TGRD_WIDTH = 1,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  clr,
  input  logic                  in_vld,
  input  logic                  in_err,
  input  logic [DAT_WIDTH-1:0]  in_dat,
  input  logic [TGRD_WIDTH-1:0] in_tgd,
  output logic                  out_vld,
  output logic                  out_err,
  output logic [DAT_WIDTH-1:0]  out_dat,
  output logic [TGRD_WIDTH-1:0] out_tgd
);

  typedef struct packed {
    logic                  vld;
    logic                  err;
    logic [DAT_WIDTH-1:0]  dat;
    logic [TGRD_WIDTH-1:0] tgd;
  } slot_t;

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("wb_tgt_ram_rsp_pipe: LATENCY out of range");
  end

  slot_t stage [LATENCY];

  always_ff @(posedge clk_i) begin
    if (clr) begin
      for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{vld: in_vld, err: in_err, dat: in_dat, tgd: in_tgd};
      for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_vld = stage[LATENCY-1].vld;
  assign out_err = stage[LATENCY-1].err;
  assign out_dat = stage[LATENCY-1].dat;
  assign out_tgd = stage[LATENCY-1].tgd;

endmodule

// File: rtl/wb_tgt_ram.sv
// Pipelined Wishbone target RAM: one request per cycle, fixed-latency
// ACK/ERR termination, out-of-range addresses answered with ERR.
module wb_tgt_ram
  import wbxbc_pkg::*;
#(
  parameter int unsigned ADR_WIDTH  = 8,
  parameter int unsigned DAT_WIDTH  = 16,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned DEPTH      = 192,
  parameter int unsigned TGA_WIDTH  = 1,
  parameter int unsigned TGRD_WIDTH = 1,
  parameter int unsigned LATENCY    = 2
) (
  input  logic          clk_i,
  input  logic          sync_rst_i,
  input  logic          stall_req_i,
  wb_tgt_ram_if.slave   tgt
);

  localparam int unsigned LANE = DAT_WIDTH / SEL_WIDTH;
  localparam logic [ADR_WIDTH:0] DEPTH_LIM = (ADR_WIDTH+1)'(DEPTH);

  logic [DAT_WIDTH-1:0]  mem [DEPTH];
  logic                  acc;
  logic                  inr;
  logic                  wr_en;
  logic [TGRD_WIDTH-1:0] tga_x;
  logic                  in_vld;
  logic                  in_err;
  logic [DAT_WIDTH-1:0]  in_dat;
  logic [TGRD_WIDTH-1:0] in_tgd;
  logic                  out_vld;
  logic                  out_err;

  if (TGRD_WIDTH > TGA_WIDTH) begin : g_tga_ext
    assign tga_x = {{(TGRD_WIDTH-TGA_WIDTH){1'b0}}, tgt.tgt_tga_i};
  end else begin : g_tga_trunc
    assign tga_x = tgt.tgt_tga_i[TGRD_WIDTH-1:0];
  end

  assign tgt.tgt_stall_o = stall_req_i;
  assign tgt.tgt_rty_o   = 1'b0;

  // Reset gates acceptance so a request coinciding with reset neither
  // commits a write nor enters the response pipeline.
  always_comb begin
    inr    = {1'b0, tgt.tgt_adr_i} < DEPTH_LIM;
    acc    = tgt.tgt_cyc_i & tgt.tgt_stb_i & ~stall_req_i & ~sync_rst_i;
    wr_en  = acc & tgt.tgt_we_i & inr;
    in_vld = acc;
    in_err = acc & ~inr;
    in_dat = '0;
    if (acc & ~tgt.tgt_we_i & inr) in_dat = mem[tgt.tgt_adr_i];
    in_tgd = acc ? tga_x : '0;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < SEL_WIDTH; k++) begin
        if (tgt.tgt_sel_i[k])
          mem[tgt.tgt_adr_i][k*LANE +: LANE] <= tgt.tgt_dat_i[k*LANE +: LANE];
      end
    end
  end

  wb_tgt_ram_rsp_pipe #(
    .DAT_WIDTH  (DAT_WIDTH),
    .TGRD_WIDTH (TGRD_WIDTH),
    .LATENCY    (LATENCY)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .clr     (sync_rst_i | ~tgt.tgt_cyc_i),
    .in_vld  (in_vld),
    .in_err  (in_err),
    .in_dat  (in_dat),
    .in_tgd  (in_tgd),
    .out_vld (out_vld),
    .out_err (out_err),
    .out_dat (tgt.tgt_dat_o),
    .out_tgd (tgt.tgt_tgd_o)
  );

  assign tgt.tgt_ack_o = out_vld & ~out_err;
  assign tgt.tgt_err_o = out_vld & out_err;

endmodule

// File: tb/tb_wb_tgt_ram.sv
// Directed bench for wb_tgt_ram (LATENCY=2, DEPTH=192): per-cycle request
// tables with hand-derived termination expectations.
module tb_wb_tgt_ram;

  logic clk = 1'b0;
  logic rst;
  logic stall_req;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_tgt_ram_if #(
    .ADR_WIDTH(8), .DAT_WIDTH(16), .SEL_WIDTH(2), .TGA_WIDTH(1), .TGRD_WIDTH(1)
  ) bus ();

  wb_tgt_ram #(
    .ADR_WIDTH(8), .DAT_WIDTH(16), .SEL_WIDTH(2), .DEPTH(192),
    .TGA_WIDTH(1), .TGRD_WIDTH(1), .LATENCY(2)
  ) dut (
    .clk_i       (clk),
    .sync_rst_i  (rst),
    .stall_req_i (stall_req),
    .tgt         (bus)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  sel;
    logic [7:0]  adr;
    logic [15:0] dat;
    logic        tga;
  } req_t;

  function automatic req_t mk_off();
    req_t r;
    r = '{rst: 1'b0, stall: 1'b0, cyc: 1'b0, stb: 1'b0, we: 1'b0,
          sel: 2'b00, adr: 8'h00, dat: 16'h0000, tga: 1'b0};
    return r;
  endfunction

  function automatic req_t mk_idle();
    req_t r;
    r = mk_off();
    r.cyc = 1'b1;
    return r;
  endfunction

  function automatic req_t mk_rd(input logic [7:0] a, input logic t);
    req_t r;
    r = mk_idle();
    r.stb = 1'b1; r.adr = a; r.tga = t;
    return r;
  endfunction

  function automatic req_t mk_wr(input logic [7:0] a, input logic [15:0] d,
                                 input logic [1:0] s, input logic t);
    req_t r;
    r = mk_rd(a, t);
    r.we = 1'b1; r.dat = d; r.sel = s;
    return r;
  endfunction

  // expected/observed termination vector: {ack, err, rty, dat, tgd}
  function automatic logic [19:0] rs(input logic a, input logic e,
                                     input logic [15:0] d, input logic t);
    return {a, e, 1'b0, d, t};
  endfunction

  function automatic logic [19:0] rsp();
    return {bus.tgt_ack_o, bus.tgt_err_o, bus.tgt_rty_o, bus.tgt_dat_o, bus.tgt_tgd_o};
  endfunction

  function automatic string fmt(input logic [19:0] v);
    return $sformatf("ack=%b err=%b rty=%b dat=%h tgd=%b", v[19], v[18], v[17], v[16:1], v[0]);
  endfunction

  task automatic drive(input req_t r);
    rst           = r.rst;
    stall_req     = r.stall;
    bus.tgt_cyc_i = r.cyc;
    bus.tgt_stb_i = r.stb;
    bus.tgt_we_i  = r.we;
    bus.tgt_sel_i = r.sel;
    bus.tgt_adr_i = r.adr;
    bus.tgt_dat_i = r.dat;
    bus.tgt_tga_i = r.tga;
  endtask

  task automatic test_reset();
    req_t rq[4]; logic [19:0] ex[4]; bit ck[4]; logic [19:0] obs;
    rq[0] = mk_wr(8'h30, 16'h5555, 2'b11, 1'b1); rq[0].rst = 1'b1;
    rq[1] = mk_rd(8'h30, 1'b1);                  rq[1].rst = 1'b1;
    rq[2] = mk_off();
    rq[3] = mk_off();
    for (int c = 1; c < 4; c++) begin ex[c] = '0; ck[c] = 1'b1; end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ck[c]) begin
        obs = rsp();
        if (obs !== ex[c]) begin
          $display("FAIL reset[%0d]: got %s want %s", c, fmt(obs), fmt(ex[c]));
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
      drive(rq[c]);
    end
  endtask

  task automatic test_write_read();
    req_t rq[6]; logic [19:0] ex[6]; bit ck[6]; logic [19:0] obs;
    rq[0] = mk_wr(8'h10, 16'hBEEF, 2'b11, 1'b1);
    rq[1] = mk_idle();
    rq[2] = mk_rd(8'h10, 1'b1);
    rq[3] = mk_idle();
    rq[4] = mk_idle();
    rq[5] = mk_off();
    ex[1] = '0;                         ck[1] = 1'b1;
    ex[2] = rs(1'b1, 1'b0, 16'h0000, 1'b1); ck[2] = 1'b1;
    ex[3] = '0;                         ck[3] = 1'b1;
    ex[4] = rs(1'b1, 1'b0, 16'hBEEF, 1'b1); ck[4] = 1'b1;
    ex[5] = '0;                         ck[5] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ck[c]) begin
        obs = rsp();
        if (obs !== ex[c]) begin
          $display("FAIL write_read[%0d]: got %s want %s", c, fmt(obs), fmt(ex[c]));
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
      drive(rq[c]);
    end
  endtask

  task automatic test_byte_lanes();
    req_t rq[8]; logic [19:0] ex[8]; bit ck[8]; logic [19:0] obs;
    rq[0] = mk_wr(8'h10, 16'h1234, 2'b01, 1'b0);
    rq[1] = mk_wr(8'h10, 16'hABCD, 2'b00, 1'b0);
    rq[2] = mk_rd(8'h10, 1'b0);
    rq[3] = mk_wr(8'h10, 16'h7700, 2'b10, 1'b1);
    rq[4] = mk_rd(8'h10, 1'b0);
    rq[5] = mk_idle();
    rq[6] = mk_idle();
    rq[7] = mk_off();
    ex[2] = rs(1'b1, 1'b0, 16'h0000, 1'b0); ck[2] = 1'b1;
    ex[3] = rs(1'b1, 1'b0, 16'h0000, 1'b0); ck[3] = 1'b1;
    ex[4] = rs(1'b1, 1'b0, 16'hBE34, 1'b0); ck[4] = 1'b1;
    ex[5] = rs(1'b1, 1'b0, 16'h0000, 1'b1); ck[5] = 1'b1;
    ex[6] = rs(1'b1, 1'b0, 16'h7734, 1'b0); ck[6] = 1'b1;
    ex[7] = '0;                         ck[7] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ck[c]) begin
        obs = rsp();
        if (obs !== ex[c]) begin
          $display("FAIL byte_lanes[%0d]: got %s want %s", c, fmt(obs), fmt(ex[c]));
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
      drive(rq[c]);
    end
  endtask

  task automatic test_out_of_range();
    req_t rq[9]; logic [19:0] ex[9]; bit ck[9]; logic [19:0] obs;
    rq[0] = mk_wr(8'hBF, 16'h0BF0, 2'b11, 1'b0);
    rq[1] = mk_rd(8'hC0, 1'b1);
    rq[2] = mk_idle();
    rq[3] = mk_wr(8'hC0, 16'hDEAD, 2'b11, 1'b0);
    rq[4] = mk_rd(8'hFF, 1'b1);
    rq[5] = mk_rd(8'hBF, 1'b0);
    rq[6] = mk_idle();
    rq[7] = mk_idle();
    rq[8] = mk_off();
    ex[2] = rs(1'b1, 1'b0, 16'h0000, 1'b0); ck[2] = 1'b1;
    ex[3] = rs(1'b0, 1'b1, 16'h0000, 1'b1); ck[3] = 1'b1;
    ex[4] = '0;                         ck[4] = 1'b1;
    ex[5] = rs(1'b0, 1'b1, 16'h0000, 1'b0); ck[5] = 1'b1;
    ex[6] = rs(1'b0, 1'b1, 16'h0000, 1'b1); ck[6] = 1'b1;
    ex[7] = rs(1'b1, 1'b0, 16'h0BF0, 1'b0); ck[7] = 1'b1;
    ex[8] = '0;                         ck[8] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (ck[c]) begin
        obs = rsp();
        if (obs !== ex[c]) begin
          $display("FAIL out_of_range[%0d]: got %s want %s", c, fmt(obs), fmt(ex[c]));
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
      drive(rq[c]);
    end
  endtask

  task automatic test_back_to_back();
    req_t rq[7]; logic [19:0] ex[7]; bit ck[7]; logic [19:0] obs;
    rq[0] = mk_wr(8'h01, 16'h1111, 2'b11, 1'b0);
    rq[1] = mk_wr(8'h02, 16'h2222, 2'b11, 1'b1);
    rq[2] = mk_wr(8'h03, 16'h3333, 2'b11, 1'b0);
    rq[3] = mk_wr(8'h04, 16'h4444, 2'b11, 1'b1);
    rq[4] = mk_idle();
    rq[5] = mk_idle();
    rq[6] = mk_off();
    ex[2] = rs(1'b1, 1'b0, 16'h0000, 1'b0); ck[2] = 1'b1;
    ex[3] = rs(1'b1, 1'b0, 16'h0000, 1'b1); ck[3] = 1'b1;
    ex[4] = rs(1'b1, 1'b0, 16'h0000, 1'b0); ck[4] = 1'b1;
    ex[5] = rs(1'b1, 1'b0, 16'h0000, 1'b1); ck[5] = 1'b1;
    ex[6] = '0;                         ck[6] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (ck[c]) begin
        obs = rsp();
        if (obs !== ex[c]) begin
          $display("FAIL back_to_back[%0d]: got %s want %s", c, fmt(obs), fmt(ex[c]));
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
      drive(rq[c]);
    end
  endtask

  task automatic test_stall_burst();
    req_t rq[9]; logic [19:0] ex[9]; bit ck[9]; logic [19:0] obs;
    rq[0] = mk_rd(8'h01, 1'b0);
    rq[1] = mk_rd(8'h02, 1'b1); rq[1].stall = 1'b1;
    rq[2] = mk_rd(8'h02, 1'b1);
    rq[3] = mk_rd(8'h03, 1'b0);
    rq[4] = mk_rd(8'h04, 1'b1);
    rq[5] = mk_idle();
    rq[6] = mk_idle();
    rq[7] = mk_idle();
    rq[8] = mk_off();
    ex[2] = rs(1'b1, 1'b0, 16'h1111, 1'b0); ck[2] = 1'b1;
    ex[3] = '0;                         ck[3] = 1'b1;
    ex[4] = rs(1'b1, 1'b0, 16'h2222, 1'b1); ck[4] = 1'b1;
    ex[5] = rs(1'b1, 1'b0, 16'h3333, 1'b0); ck[5] = 1'b1;
    ex[6] = rs(1'b1, 1'b0, 16'h4444, 1'b1); ck[6] = 1'b1;
    ex[7] = '0;                         ck[7] = 1'b1;
    ex[8] = '0;                         ck[8] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (ck[c]) begin
        obs = rsp();
        if (obs !== ex[c]) begin
          $display("FAIL stall_burst[%0d]: got %s want %s", c, fmt(obs), fmt(ex[c]));
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
      drive(rq[c]);
      if (c == 1 || c == 2) begin
        #1;
        if (bus.tgt_stall_o !== rq[c].stall) begin
          $display("FAIL stall_out[%0d]: got %b want %b", c, bus.tgt_stall_o, rq[c].stall);
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
    end
  endtask

  task automatic test_abort();
    req_t rq[7]; logic [19:0] ex[7]; bit ck[7]; logic [19:0] obs;
    rq[0] = mk_rd(8'h01, 1'b0);
    rq[1] = mk_rd(8'h02, 1'b1);
    rq[2] = mk_off();
    rq[3] = mk_rd(8'h03, 1'b1);
    rq[4] = mk_idle();
    rq[5] = mk_idle();
    rq[6] = mk_off();
    ex[3] = '0;                         ck[3] = 1'b1;
    ex[4] = '0;                         ck[4] = 1'b1;
    ex[5] = rs(1'b1, 1'b0, 16'h3333, 1'b1); ck[5] = 1'b1;
    ex[6] = '0;                         ck[6] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (ck[c]) begin
        obs = rsp();
        if (obs !== ex[c]) begin
          $display("FAIL abort[%0d]: got %s want %s", c, fmt(obs), fmt(ex[c]));
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
      drive(rq[c]);
    end
  endtask

  task automatic test_reset_midflight();
    req_t rq[9]; logic [19:0] ex[9]; bit ck[9]; logic [19:0] obs;
    rq[0] = mk_wr(8'h20, 16'hAAAA, 2'b11, 1'b0);
    rq[1] = mk_idle();
    rq[2] = mk_rd(8'h20, 1'b1);
    rq[3] = mk_wr(8'h20, 16'h5555, 2'b11, 1'b0); rq[3].rst = 1'b1;
    rq[4] = mk_idle();
    rq[5] = mk_rd(8'h20, 1'b1);
    rq[6] = mk_idle();
    rq[7] = mk_idle();
    rq[8] = mk_off();
    ex[2] = rs(1'b1, 1'b0, 16'h0000, 1'b0); ck[2] = 1'b1;
    for (int c = 3; c < 7; c++) begin ex[c] = '0; ck[c] = 1'b1; end
    ex[7] = rs(1'b1, 1'b0, 16'hAAAA, 1'b1); ck[7] = 1'b1;
    ex[8] = '0;                         ck[8] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (ck[c]) begin
        obs = rsp();
        if (obs !== ex[c]) begin
          $display("FAIL reset_midflight[%0d]: got %s want %s", c, fmt(obs), fmt(ex[c]));
          n_fail++;
        end else n_pass++;
        n_chk++;
      end
      drive(rq[c]);
    end
  endtask

  initial begin
    drive(mk_off());
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_stall_burst();
    test_abort();
    test_reset_midflight();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
